// File: rtl/psk_demod.sv
// Coherent BPSK/QPSK hard-decision demodulator.
// Integrates 16 baseband I/Q samples per symbol (integrate-and-dump), slices the sign of
// the sums and presents one symbol per window on a single-register AXI-Stream master.
module psk_demod #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned BYTES = 1
) (
  input  logic                    clk_16M384,
  input  logic                    rst_16M384,
  input  logic signed [WIDTH-1:0] in_I,
  input  logic signed [WIDTH-1:0] in_Q,
  input  logic                    in_vld,
  input  logic                    in_last,
  input  logic                    in_is_bpsk,
  input  logic [3:0]              DELAY_CNT,
  output logic [BYTES*8-1:0]      out_tdata,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic                    out_tlast,
  output logic                    out_tuser,
  output logic signed [WIDTH+3:0] out_acc_I,
  output logic signed [WIDTH+3:0] out_acc_Q,
  output logic                    overflow
);

  localparam int unsigned AccW = WIDTH + 4;
  localparam int unsigned DataW = BYTES * 8;

  typedef enum logic [0:0] {StSync, StRun} state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [3:0] r_cnt;
  logic [3:0] r_dly;

  logic signed [AccW-1:0] r_acc_i;
  logic signed [AccW-1:0] r_acc_q;
  logic                   r_bad;
  logic                   r_lastf;
  logic                   r_mode;

  logic [DataW-1:0]       r_tdata;
  logic                   r_tvalid;
  logic                   r_tlast;
  logic                   r_tuser;
  logic signed [AccW-1:0] r_out_acc_i;
  logic signed [AccW-1:0] r_out_acc_q;
  logic                   r_overflow;

  logic                   w_dly_chg;
  logic                   w_at_dly;
  logic [3:0]             w_dly_p1;
  logic                   w_first;
  logic signed [AccW-1:0] w_sext_i;
  logic signed [AccW-1:0] w_sext_q;
  logic signed [AccW-1:0] w_sum_i;
  logic signed [AccW-1:0] w_sum_q;
  logic                   w_bad;
  logic                   w_lastf;
  logic                   w_mode;
  logic [1:0]             w_bits;
  logic                   w_clr;
  logic                   w_accum;
  logic                   w_dump;
  logic                   w_load;
  logic                   w_slot_free;

  // Window timing: the window closes on cnt == dly and the next one opens one clock later.
  assign w_dly_chg = (DELAY_CNT != r_dly);
  assign w_at_dly  = (r_cnt == r_dly);
  assign w_dly_p1  = r_dly + 4'd1;
  assign w_first   = (r_cnt == w_dly_p1);

  // Running sums include the current sample so the dump clock sees the complete window.
  assign w_sext_i = {{4{in_I[WIDTH-1]}}, in_I};
  assign w_sext_q = {{4{in_Q[WIDTH-1]}}, in_Q};
  assign w_sum_i  = r_acc_i + w_sext_i;
  assign w_sum_q  = r_acc_q + w_sext_q;
  assign w_bad    = r_bad | ~in_vld;
  assign w_lastf  = r_lastf | in_last;
  // Mode is captured on the first window sample; later changes inside the window are ignored.
  assign w_mode   = w_first ? in_is_bpsk : r_mode;

  // Sign slicer; a zero sum decides as positive.
  assign w_bits = w_mode ? {~w_sum_i[AccW-1], 1'b0}
                         : {w_sum_i[AccW-1], w_sum_q[AccW-1]};

  // Only windows with every sample valid produce a symbol.
  assign w_load      = w_dump & ~w_bad;
  // Output register can take a new symbol if empty or being drained this clock.
  assign w_slot_free = ~r_tvalid | out_tready;

  // Free-running symbol-phase counter and registered alignment setting.
  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      r_cnt <= 4'd0;
      r_dly <= 4'd0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
      r_dly <= DELAY_CNT;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      r_state <= StSync;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: SYNC waits for the alignment point, RUN integrates until the phase moves.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_accum     = 1'b0;
    w_dump      = 1'b0;
    unique case (r_state)
      StSync: begin
        if (!w_dly_chg && w_at_dly) begin
          w_state_nxt = StRun;
          w_clr       = 1'b1;
        end
      end
      StRun: begin
        if (w_dly_chg) begin
          // Abort the partial window; the held output symbol is left alone.
          w_state_nxt = StSync;
        end else begin
          w_accum = 1'b1;
          w_dump  = w_at_dly;
        end
      end
      default: w_state_nxt = StSync;
    endcase
  end

  // Integrators and per-window flags; cleared on dump so the next window starts without a gap.
  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_bad   <= 1'b0;
      r_lastf <= 1'b0;
      r_mode  <= 1'b0;
    end else if (w_clr || w_dump) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_bad   <= 1'b0;
      r_lastf <= 1'b0;
    end else if (w_accum) begin
      r_acc_i <= w_sum_i;
      r_acc_q <= w_sum_q;
      r_bad   <= w_bad;
      r_lastf <= w_lastf;
      r_mode  <= w_mode;
    end
  end

  // AXIS output register with sticky overflow when a good symbol meets a stalled slot.
  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_out_acc_i <= '0;
      r_out_acc_q <= '0;
      r_overflow  <= 1'b0;
    end else if (w_load && w_slot_free) begin
      r_tdata     <= {{(DataW-2){1'b0}}, w_bits};
      r_tvalid    <= 1'b1;
      r_tlast     <= w_lastf;
      r_tuser     <= w_mode;
      r_out_acc_i <= w_sum_i;
      r_out_acc_q <= w_sum_q;
    end else begin
      if (w_load) begin
        r_overflow <= 1'b1;
      end
      if (r_tvalid && out_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign out_tdata  = r_tdata;
  assign out_tvalid = r_tvalid;
  assign out_tlast  = r_tlast;
  assign out_tuser  = r_tuser;
  assign out_acc_I  = r_out_acc_i;
  assign out_acc_Q  = r_out_acc_q;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_psk_demod.sv
// Directed self-checking bench for psk_demod: windows of 16 samples driven back to back,
// outputs checked 1 ns after the clock edge that should have produced them.
`timescale 1ns/1ps
module tb_psk_demod;

  logic               clk;
  logic               rst;
  logic signed [11:0] in_i;
  logic signed [11:0] in_q;
  logic               in_vld;
  logic               in_last;
  logic               in_bpsk;
  logic [3:0]         dly;
  logic [7:0]         tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;
  logic               tuser;
  logic signed [15:0] acc_i;
  logic signed [15:0] acc_q;
  logic               ovf;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_xfer = 0;
  logic [7:0]         x_data;
  logic signed [15:0] x_acc_i;

  psk_demod #(.WIDTH(12), .BYTES(1)) dut (
    .clk_16M384 (clk),
    .rst_16M384 (rst),
    .in_I       (in_i),
    .in_Q       (in_q),
    .in_vld     (in_vld),
    .in_last    (in_last),
    .in_is_bpsk (in_bpsk),
    .DELAY_CNT  (dly),
    .out_tdata  (tdata),
    .out_tvalid (tvalid),
    .out_tready (tready),
    .out_tlast  (tlast),
    .out_tuser  (tuser),
    .out_acc_I  (acc_i),
    .out_acc_Q  (acc_q),
    .overflow   (ovf)
  );

  initial clk = 1'b0;
  always #30 clk = ~clk;

  // Record completed AXIS transfers.
  always @(posedge clk) begin
    if (!rst && tvalid && tready) begin
      n_xfer  <= n_xfer + 1;
      x_data  <= tdata;
      x_acc_i <= acc_i;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n identical samples, one per clock.
  task automatic drive(input int n, input int vi, input int vq, input logic vld,
                       input logic bpsk, input logic last);
    for (int k = 0; k < n; k++) begin
      in_i    = 12'(vi);
      in_q    = 12'(vq);
      in_vld  = vld;
      in_bpsk = bpsk;
      in_last = last;
      tick();
    end
  endtask

  int                 q_sum;
  int                 x0;
  logic signed [11:0] rq;

  initial begin
    rst = 1'b1; in_i = '0; in_q = '0; in_vld = 1'b0; in_last = 1'b0; in_bpsk = 1'b0;
    dly = 4'd0; tready = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_acc_i", acc_i, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    // cnt==0 edge: SYNC -> RUN, window then covers cnt 1..15,0.
    drive(1, 0, 0, 1'b0, 1'b0, 1'b0);

    // 1: QPSK +100/-50
    drive(15, 100, -50, 1'b1, 1'b0, 1'b0);
    check("t1_latency", tvalid, 0);
    drive(1, 100, -50, 1'b1, 1'b0, 1'b0);
    check("t1_tvalid", tvalid, 1);
    check("t1_tdata", tdata, 1);
    check("t1_acc_i", acc_i, 1600);
    check("t1_acc_q", acc_q, -800);
    check("t1_tuser", tuser, 0);
    check("t1_tlast", tlast, 0);
    drive(1, 0, 0, 1'b0, 1'b0, 1'b0);
    check("t1_drop", tvalid, 0);
    drive(15, 0, 0, 1'b0, 1'b0, 1'b0);

    // 2: BPSK extremes, random Q
    q_sum = 0;
    for (int k = 0; k < 16; k++) begin
      rq = 12'($urandom); q_sum += rq;
      in_i = -12'sd2048; in_q = rq; in_vld = 1'b1; in_bpsk = 1'b1; in_last = 1'b0;
      tick();
    end
    check("t2a_tdata", tdata, 0);
    check("t2a_acc_i", acc_i, -32768);
    check("t2a_acc_q", acc_q, q_sum);
    check("t2a_tuser", tuser, 1);
    // Mode drops to QPSK after the first sample; the latched BPSK decision must hold.
    for (int k = 0; k < 16; k++) begin
      rq = 12'($urandom);
      in_i = 12'sd2047; in_q = rq; in_vld = 1'b1; in_bpsk = (k == 0); in_last = 1'b0;
      tick();
    end
    check("t2b_tdata", tdata, 2);
    check("t2b_acc_i", acc_i, 32752);
    check("t2b_tuser", tuser, 1);

    // 3: quadrant sweep with frame end on 4th symbol
    drive(16, 20, 20, 1'b1, 1'b0, 1'b0);
    check("t3_s1_tdata", tdata, 0);
    check("t3_s1_tlast", tlast, 0);
    drive(16, -20, 20, 1'b1, 1'b0, 1'b0);
    check("t3_s2_tdata", tdata, 2);
    check("t3_s2_tvalid", tvalid, 1);
    drive(16, -20, -20, 1'b1, 1'b0, 1'b0);
    check("t3_s3_tdata", tdata, 3);
    check("t3_s3_tlast", tlast, 0);
    drive(6, 20, -20, 1'b1, 1'b0, 1'b0);
    drive(1, 20, -20, 1'b1, 1'b0, 1'b1);
    drive(9, 20, -20, 1'b1, 1'b0, 1'b0);
    check("t3_s4_tdata", tdata, 1);
    check("t3_s4_tlast", tlast, 1);
    drive(16, 0, 0, 1'b0, 1'b0, 1'b0);

    // 4: invalid sample in window 2 discards only that symbol
    x0 = n_xfer;
    drive(16, 50, 50, 1'b1, 1'b0, 1'b0);
    check("t4_s1_tdata", tdata, 0);
    drive(5, -50, -50, 1'b1, 1'b0, 1'b0);
    drive(1, -50, -50, 1'b0, 1'b0, 1'b0);
    drive(10, -50, -50, 1'b1, 1'b0, 1'b0);
    check("t4_s2_tvalid", tvalid, 0);
    drive(16, -50, 50, 1'b1, 1'b0, 1'b0);
    check("t4_s3_tdata", tdata, 2);
    check("t4_s3_acc_i", acc_i, -800);
    drive(1, 0, 0, 1'b0, 1'b0, 1'b0);
    check("t4_xfers", n_xfer - x0, 2);
    check("t4_ovf", ovf, 0);
    drive(15, 0, 0, 1'b0, 1'b0, 1'b0);

    // 5: backpressure across three good symbols
    tready = 1'b0;
    x0 = n_xfer;
    drive(16, 10, 10, 1'b1, 1'b0, 1'b0);
    check("t5_s1_tvalid", tvalid, 1);
    check("t5_s1_ovf", ovf, 0);
    drive(16, -10, 10, 1'b1, 1'b0, 1'b0);
    check("t5_s2_ovf", ovf, 1);
    check("t5_s2_tdata", tdata, 0);
    check("t5_s2_acc_i", acc_i, 160);
    drive(16, -10, -10, 1'b1, 1'b0, 1'b0);
    check("t5_s3_tdata", tdata, 0);
    check("t5_s3_tvalid", tvalid, 1);
    tready = 1'b1;
    drive(1, 0, 0, 1'b0, 1'b0, 1'b0);
    check("t5_xfers", n_xfer - x0, 1);
    check("t5_x_data", x_data, 0);
    check("t5_x_acc_i", x_acc_i, 160);
    check("t5_tvalid_off", tvalid, 0);
    check("t5_ovf_sticky", ovf, 1);
    drive(15, 0, 0, 1'b0, 1'b0, 1'b0);

    // 6: realign to cnt==5 mid-window, then reset mid-window with a held symbol
    x0 = n_xfer;
    drive(8, 3, 3, 1'b1, 1'b0, 1'b0);
    dly = 4'd5;
    drive(13, -100, 100, 1'b1, 1'b0, 1'b0);
    drive(15, 7, -7, 1'b1, 1'b0, 1'b0);
    check("t6_abort_tvalid", tvalid, 0);
    check("t6_abort_xfers", n_xfer - x0, 0);
    tready = 1'b0;
    drive(1, 7, -7, 1'b1, 1'b0, 1'b0);
    check("t6_tvalid", tvalid, 1);
    check("t6_tdata", tdata, 1);
    check("t6_acc_i", acc_i, 112);
    check("t6_acc_q", acc_q, -112);
    drive(5, 7, -7, 1'b1, 1'b0, 1'b0);
    check("t6_held", tvalid, 1);
    rst = 1'b1;
    tick();
    check("t6_rst_tvalid", tvalid, 0);
    check("t6_rst_tdata", tdata, 0);
    check("t6_rst_tlast", tlast, 0);
    check("t6_rst_tuser", tuser, 0);
    check("t6_rst_acc_i", acc_i, 0);
    check("t6_rst_acc_q", acc_q, 0);
    check("t6_rst_ovf", ovf, 0);
    rst = 1'b0;
    drive(1, 7, -7, 1'b1, 1'b0, 1'b0);
    check("t6_post_tvalid", tvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
